// File: rtl/fa_pkg.sv
// ----------------------------------------------------------------------------
// fa_pkg
// Purpose : Shared defaults and helper for the full_adder datapath leaf.
//           Holds the WIDTH / REG_OUT build defaults and the majority
//           function that forms the carry of a 1-bit full-adder cell.
// Contents:
//   FA_WIDTH_DEFAULT    default operand width (1-bit full adder)
//   FA_REG_OUT_DEFAULT  default output staging (0 = combinational)
//   fa_majority()       carry-out of a 1-bit cell: majority of a, b, ci
// ----------------------------------------------------------------------------
package fa_pkg;

  localparam int unsigned FA_WIDTH_DEFAULT   = 32'd1;
  localparam bit          FA_REG_OUT_DEFAULT = 1'b0;

  // Carry of a full-adder cell: set when at least two of the three inputs are set.
  function automatic logic fa_majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage : fa_pkg

// File: rtl/fa_cell.sv
// ----------------------------------------------------------------------------
// fa_cell
// Purpose : 1-bit combinational full adder, the building block of the
//           ripple-carry chain inside full_adder.
// Ports   :
//   i_a   in  1  operand bit A
//   i_b   in  1  operand bit B
//   i_ci  in  1  carry-in from the next lower bit
//   o_s   out 1  sum bit
//   o_co  out 1  carry-out to the next higher bit
// ----------------------------------------------------------------------------
module fa_cell
  import fa_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = fa_majority(i_a, i_b, i_ci);

endmodule : fa_cell

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// Purpose : WIDTH-bit ripple-carry adder built from fa_cell instances,
//           computing {c_out, sum_out} = a_in + b_in + c_in exactly.
//           With REG_OUT=1 the result is captured by an output register
//           (1-cycle latency, async active-low reset clears it).
// Parameters:
//   WIDTH    operand width in bits (>= 1)
//   REG_OUT  0 = combinational outputs, 1 = outputs registered on clk
// Ports   :
//   clk      in  1      rising-edge clock (only used when REG_OUT=1)
//   rst_n    in  1      async active-low reset (only used when REG_OUT=1)
//   a_in     in  WIDTH  operand A, unsigned
//   b_in     in  WIDTH  operand B, unsigned
//   c_in     in  1      carry into bit 0
//   sum_out  out WIDTH  sum bits
//   c_out    out 1      carry out of the MSB
// ----------------------------------------------------------------------------
module full_adder
  import fa_pkg::*;
#(
  parameter int unsigned WIDTH   = FA_WIDTH_DEFAULT,
  parameter bit          REG_OUT = FA_REG_OUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);

  // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_carry[0] = c_in;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    fa_cell u_cell (
      .i_a  (a_in[gi]),
      .i_b  (b_in[gi]),
      .i_ci (w_carry[gi]),
      .o_s  (w_sum[gi]),
      .o_co (w_carry[gi+1])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    // Output stage: captures the ripple result on every edge, cleared at once by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum  <= {WIDTH{1'b0}};
        r_cout <= 1'b0;
      end else begin
        r_sum  <= w_sum;
        r_cout <= w_carry[WIDTH];
      end
    end

    assign sum_out = r_sum;
    assign c_out   = r_cout;
  end else begin : g_comb
    // clk and rst_n have no function in the combinational build; they are
    // gathered here only so the unused inputs are visibly accounted for.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk & rst_n;

    assign sum_out = w_sum;
    assign c_out   = w_carry[WIDTH];
  end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// ----------------------------------------------------------------------------
// tb_full_adder
// Purpose : Self-checking bench for full_adder in three builds:
//           WIDTH=1/REG_OUT=0, WIDTH=8/REG_OUT=0 and WIDTH=4/REG_OUT=1.
// ----------------------------------------------------------------------------
module tb_full_adder;

  int n_checks = 0;
  int n_errors = 0;

  // Shared clock for the registered build; the combinational builds get
  // never-driven clk/rst_n nets.
  logic clk = 1'b0;
  logic rst_n;
  logic clk_nc;
  logic rst_n_nc;

  always #5 clk = ~clk;

  // WIDTH=1, combinational
  logic       a1, b1, c1, s1, co1;
  // WIDTH=8, combinational
  logic [7:0] a8, b8, s8;
  logic       c8, co8;
  // WIDTH=4, registered
  logic [3:0] a4, b4, s4;
  logic       c4, co4;

  full_adder #(.WIDTH(32'd1), .REG_OUT(1'b0)) u_dut1 (
    .clk(clk_nc), .rst_n(rst_n_nc), .a_in(a1), .b_in(b1), .c_in(c1),
    .sum_out(s1), .c_out(co1)
  );

  full_adder #(.WIDTH(32'd8), .REG_OUT(1'b0)) u_dut8 (
    .clk(clk_nc), .rst_n(rst_n_nc), .a_in(a8), .b_in(b8), .c_in(c8),
    .sum_out(s8), .c_out(co8)
  );

  full_adder #(.WIDTH(32'd4), .REG_OUT(1'b1)) u_dut4r (
    .clk(clk), .rst_n(rst_n), .a_in(a4), .b_in(b4), .c_in(c4),
    .sum_out(s4), .c_out(co4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Truth table for WIDTH=1, indexed by {a,b,c}: value is {carry,sum}.
  logic [1:0] tt [8];
  logic [8:0] exp9;
  logic [4:0] exp5;

  initial begin
    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    a4 = 4'h0;  b4 = 4'h0;  c4 = 1'b0;

    // ---------------- WIDTH=1 exhaustive ----------------
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      #1;
      check($sformatf("w1_tt_%0d", i), {30'd0, co1, s1}, {30'd0, tt[i]});
    end

    // ---------------- WIDTH=8 directed ----------------
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; #1;
    check("w8_ff_01_0", {23'd0, co8, s8}, 32'h100);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; #1;
    check("w8_ff_ff_1", {23'd0, co8, s8}, 32'h1FF);
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; #1;
    check("w8_zero", {23'd0, co8, s8}, 32'h000);
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; #1;
    check("w8_ripple", {23'd0, co8, s8}, 32'h100);
    a8 = 8'h5A; b8 = 8'hA5; c8 = 1'b0; #1;
    check("w8_5a_a5", {23'd0, co8, s8}, 32'h0FF);
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b1; #1;
    check("w8_msb", {23'd0, co8, s8}, 32'h101);

    // ---------------- WIDTH=8 random vs a+b+c ----------------
    for (int i = 0; i < 10000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      exp9 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
      #1;
      check("w8_rand", {23'd0, co8, s8}, {23'd0, exp9});
    end

    // ---------------- WIDTH=4 registered ----------------
    // Reset asserted from time 0: outputs must already be clear.
    #1;
    check("r4_in_reset", {27'd0, co4, s4}, 32'h00);
    @(negedge clk);
    a4 = 4'd1; b4 = 4'd1; c4 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("r4_first_after_rst", {27'd0, co4, s4}, 32'h02);

    // Latency: new inputs before edge N show only after edge N.
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd4; c4 = 1'b1;
    #1;
    check("r4_before_edge", {27'd0, co4, s4}, 32'h02);
    @(posedge clk); #1;
    check("r4_after_edge", {27'd0, co4, s4}, 32'h08);

    // Async reset between edges, with in-flight inputs discarded.
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("r4_async_clear", {27'd0, co4, s4}, 32'h00);
    @(posedge clk); #1;
    check("r4_hold_in_reset", {27'd0, co4, s4}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("r4_release_no_edge", {27'd0, co4, s4}, 32'h00);
    @(posedge clk); #1;
    check("r4_load_after_release", {27'd0, co4, s4}, 32'h1F);

    // Streaming: inputs change every cycle, each edge loads its own result.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      c4 = 1'($urandom);
      exp5 = {1'b0, a4} + {1'b0, b4} + {4'd0, c4};
      @(posedge clk); #1;
      check("r4_stream", {27'd0, co4, s4}, {27'd0, exp5});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_full_adder
